scoreboard_regfile: RTL

- Parametrised successor to the pipeline's register file with hazard flags.
- Sits between decode and writeback.
- Holds NUM_REGS x DATA_W architectural registers, with two combinational read ports, one synchronous writeback port and a write-through bypass.
- Each register has a per-register pending-write counter, replacing the single hazard bit, so decode sees correct readiness with several outstanding writes (WAW) to one register.

---
 rtl/scoreboard_regfile.sv | 124 ++++++++++++
 1 files changed

// File: rtl/scoreboard_regfile.sv
// scoreboard_regfile
//   Architectural register file with per-register pending-write counters.
//   Decode reads operands and readiness here, and commits destinations
//   through the issue port. Writeback retires those pending writes.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   rd_addr1/2            read indices
//   rd_data1/2            combinational read data (writeback bypass included)
//   rd_ready1/2           1 = no write to that register is still outstanding
//                         once this cycle's writeback is taken into account
//   issue_en, issue_addr  decode commits an instruction that writes issue_addr
//   issue_stall           issue_addr's counter is full; the issue is dropped
//   wb_en, wb_addr,       writeback of one result
//   wb_data
//   pend_err              sticky: a writeback arrived with nothing pending
//
// Issue handshake: issue_en is "valid" and ~issue_stall is "ready". An issue
// takes effect only in a cycle where issue_en=1 and issue_stall=0. When
// issue_stall=1, decode must hold the same instruction and present it again.
module scoreboard_regfile #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int PEND_W   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_ready1,
    output logic              rd_ready2,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic              issue_stall,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              pend_err
);

    localparam logic [PEND_W-1:0] CNT_MAX = '1;
    localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [PEND_W-1:0]   cnt  [NUM_REGS];
    logic [NUM_REGS-1:0] inc_vec;
    logic [NUM_REGS-1:0] dec_vec;

    // Register 0 is hardwired when ZERO_REG is set.
    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    function automatic logic [DATA_W-1:0] port_data(input logic [ADDR_W-1:0] a);
        if (is_zero(a))
            return '0;
        else if (wb_en && (wb_addr == a))
            return wb_data;
        else
            return regs[a];
    endfunction

    // Ready if nothing is pending, or the only pending write retires this cycle.
    function automatic logic port_ready(input logic [ADDR_W-1:0] a);
        if (is_zero(a))
            return 1'b1;
        return (cnt[a] == '0) ||
               ((cnt[a] == CNT_ONE) && wb_en && (wb_addr == a));
    endfunction

    always_comb begin
        rd_data1  = port_data(rd_addr1);
        rd_data2  = port_data(rd_addr2);
        rd_ready1 = port_ready(rd_addr1);
        rd_ready2 = port_ready(rd_addr2);
    end

    // A same-cycle writeback to the issue target frees a slot, so a full
    // counter does not stall in that case.
    always_comb begin
        issue_stall = issue_en && !is_zero(issue_addr) &&
                      (cnt[issue_addr] == CNT_MAX) &&
                      !(wb_en && (wb_addr == issue_addr));
    end

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            inc_vec[r] = issue_en && (issue_addr == ADDR_W'(r)) &&
                         !issue_stall && !is_zero(ADDR_W'(r));
            dec_vec[r] = wb_en && (wb_addr == ADDR_W'(r)) &&
                         (cnt[r] != '0) && !is_zero(ADDR_W'(r));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
                cnt[r]  <= '0;
            end
            pend_err <= 1'b0;
        end else begin
            if (wb_en && !is_zero(wb_addr)) begin
                regs[wb_addr] <= wb_data;
                // Unexpected writeback: still committed, but flagged.
                if (cnt[wb_addr] == '0)
                    pend_err <= 1'b1;
            end
            for (int r = 0; r < NUM_REGS; r++) begin
                if (inc_vec[r] && !dec_vec[r])
                    cnt[r] <= cnt[r] + CNT_ONE;
                else if (dec_vec[r] && !inc_vec[r])
                    cnt[r] <= cnt[r] - CNT_ONE;
            end
        end
    end

endmodule
